// File: rtl/core_pipe_pkg.sv
// +-----------------------------------------------------------------------+
// | core_pipe_pkg: shared widths and control-bundle layout. Rev 1.0        |
// +-----------------------------------------------------------------------+
`default_nettype none

package core_pipe_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CTRL_W   = 9;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_JUMP     = 6;
  localparam int CTRL_ALUOP_LO = 7;
  localparam int CTRL_ALUOP_HI = 8;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// +-----------------------------------------------------------------------+
// | load_use_detect: flags an ID consumer of a load still in EX. Rev 1.0   |
// +-----------------------------------------------------------------------+
`default_nettype none

module load_use_detect (
  input  logic       i_ex_valid,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  output logic       o_hz
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

  // x0 is never a real producer, so a load targeting it cannot stall.
  assign o_hz = i_ex_valid && i_ex_memread && (i_ex_rd != 5'd0) && i_id_valid
                && (w_rs1_hit || w_rs2_hit);
endmodule

`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
// +-----------------------------------------------------------------------+
// | id_ex_stage_reg: ID/EX register, load-use bubbles, stall counter.      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module id_ex_stage_reg
  import core_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CTRL_W = core_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [3:0]        id_funct,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              ID_EX_valid,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic [XLEN-1:0]   ID_EX_rs1_data,
  output logic [XLEN-1:0]   ID_EX_rs2_data,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [4:0]        ID_EX_rs1,
  output logic [4:0]        ID_EX_rs2,
  output logic [4:0]        ID_EX_rd,
  output logic [3:0]        ID_EX_funct,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_count
);
  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [3:0]        r_funct;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_count;
  logic              w_hz;
  logic              w_stall;
  logic              w_bubble;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_memread  (r_ctrl[CTRL_MEMREAD]),
    .i_ex_rd       (r_rd),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_uses_rs1 (id_uses_rs1),
    .i_id_uses_rs2 (id_uses_rs2),
    .o_hz          (w_hz)
  );

  // A flushed consumer is being discarded, so it must not hold the front end.
  assign w_stall  = w_hz && !flush;
  assign w_bubble = flush || (!hold && w_stall);

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_funct    <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (!hold) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_funct    <= id_funct;
      r_ctrl     <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && !hold && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign ID_EX_valid    = r_valid;
  assign ID_EX_pc       = r_pc;
  assign ID_EX_rs1_data = r_rs1_data;
  assign ID_EX_rs2_data = r_rs2_data;
  assign ID_EX_imm      = r_imm;
  assign ID_EX_rs1      = r_rs1;
  assign ID_EX_rs2      = r_rs2;
  assign ID_EX_rd       = r_rd;
  assign ID_EX_funct    = r_funct;
  assign ID_EX_ctrl     = r_ctrl;
  assign load_use_stall = w_stall;
  assign PCWrite        = !(w_stall || hold);
  assign IF_ID_Write    = !(w_stall || hold);
  assign stall_count    = r_stall_count;
endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
// +-----------------------------------------------------------------------+
// | tb_id_ex_stage_reg: directed checks of the ID/EX register. Rev 1.0     |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage_reg;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 2;

  localparam logic [8:0] C_ADD  = 9'h001;
  localparam logic [8:0] C_LW   = 9'h01B;
  localparam logic [8:0] C_ADDI = 9'h011;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [3:0]        id_funct;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic              hold;
  logic              ID_EX_valid;
  logic [XLEN-1:0]   ID_EX_pc;
  logic [XLEN-1:0]   ID_EX_rs1_data;
  logic [XLEN-1:0]   ID_EX_rs2_data;
  logic [XLEN-1:0]   ID_EX_imm;
  logic [4:0]        ID_EX_rs1;
  logic [4:0]        ID_EX_rs2;
  logic [4:0]        ID_EX_rd;
  logic [3:0]        ID_EX_funct;
  logic [CTRL_W-1:0] ID_EX_ctrl;
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              load_use_stall;
  logic [CNT_W-1:0]  stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_funct(id_funct), .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_funct(ID_EX_funct), .ID_EX_ctrl(ID_EX_ctrl),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs and samples land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [8:0] ctrl);
    id_valid    = 1'b1;
    id_pc       = pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_rs1_data = pc ^ 32'hA5A5_0000;
    id_rs2_data = pc ^ 32'h0000_5A5A;
    id_imm      = pc + 32'd4;
    id_funct    = pc[3:0];
    id_ctrl     = ctrl;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rs1_data = '0; id_rs2_data = '0;
    id_imm = '0; id_funct = '0; id_ctrl = '0;
    tick(); tick();
    chk("rst_valid", 32'(ID_EX_valid), 32'd0);
    chk("rst_ctrl", 32'(ID_EX_ctrl), 32'd0);
    chk("rst_pc", ID_EX_pc, 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd1);
    rst = 1'b0;

    // add x3,x1,x2
    present(32'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD);
    tick();
    chk("add_valid", 32'(ID_EX_valid), 32'd1);
    chk("add_rd", 32'(ID_EX_rd), 32'd3);
    chk("add_pc", ID_EX_pc, 32'h100);
    chk("add_rs1_data", ID_EX_rs1_data, 32'hA5A5_0100);
    chk("add_imm", ID_EX_imm, 32'h104);
    chk("add_ctrl", 32'(ID_EX_ctrl), 32'(C_ADD));
    chk("add_pcwrite", 32'(PCWrite), 32'd1);

    // lw x5 then dependent add x6,x5,x7
    present(32'h104, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    tick();
    present(32'h108, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, C_ADD);
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    chk("lu_pcwrite", 32'(PCWrite), 32'd0);
    chk("lu_ifid", 32'(IF_ID_Write), 32'd0);
    tick();
    chk("lu_bubble_valid", 32'(ID_EX_valid), 32'd0);
    chk("lu_bubble_ctrl", 32'(ID_EX_ctrl), 32'd0);
    chk("lu_cnt1", 32'(stall_count), 32'd1);
    chk("lu_resolved", 32'(PCWrite), 32'd1);
    tick();
    chk("lu_cap_valid", 32'(ID_EX_valid), 32'd1);
    chk("lu_cap_rs1", 32'(ID_EX_rs1), 32'd5);
    chk("lu_cap_pc", ID_EX_pc, 32'h108);

    // lw x0 never stalls
    present(32'h10C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, C_LW);
    tick();
    present(32'h110, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD);
    chk("x0_nostall", 32'(load_use_stall), 32'd0);
    // lw x5, then I-type whose rs2 field is 5 but unused
    present(32'h114, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    tick();
    present(32'h118, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, C_ADDI);
    chk("itype_nostall", 32'(load_use_stall), 32'd0);
    tick();
    chk("itype_cap_rd", 32'(ID_EX_rd), 32'd6);

    // flush beats hazard and hold
    present(32'h11C, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    tick();
    present(32'h120, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD);
    flush = 1'b1; hold = 1'b1; #1;
    chk("flush_nostall", 32'(load_use_stall), 32'd0);
    chk("flush_hold_pcw", 32'(PCWrite), 32'd0);
    tick();
    chk("flush_valid", 32'(ID_EX_valid), 32'd0);
    chk("flush_ctrl", 32'(ID_EX_ctrl), 32'd0);
    chk("flush_cnt", 32'(stall_count), 32'd1);
    flush = 1'b0; hold = 1'b0;

    // hold freezes while id_* changes
    present(32'h200, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, C_ADD);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(32'h300 + 32'(i), 5'd1, 5'd2, 5'(10 + i), 1'b1, 1'b1, C_ADD);
      chk("hold_pcwrite", 32'(PCWrite), 32'd0);
      tick();
      chk("hold_pc", ID_EX_pc, 32'h200);
      chk("hold_rd", 32'(ID_EX_rd), 32'd9);
    end
    hold = 1'b0;
    tick();
    chk("release_pc", ID_EX_pc, 32'h302);
    chk("release_rd", 32'(ID_EX_rd), 32'd12);

    // hazard under hold: no count, re-evaluated after release
    present(32'h400, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    tick();
    present(32'h404, 5'd0, 5'd5, 5'd6, 1'b0, 1'b1, C_ADD);
    hold = 1'b1; #1;
    chk("hzhold_stall", 32'(load_use_stall), 32'd1);
    tick();
    chk("hzhold_cnt", 32'(stall_count), 32'd1);
    chk("hzhold_pc", ID_EX_pc, 32'h400);
    hold = 1'b0; #1;
    chk("hzrel_stall", 32'(load_use_stall), 32'd1);
    tick();
    chk("hzrel_valid", 32'(ID_EX_valid), 32'd0);
    chk("hzrel_cnt", 32'(stall_count), 32'd2);

    // reset mid-stall
    present(32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
    tick();
    present(32'h504, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD);
    chk("midrst_stall", 32'(load_use_stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cnt", 32'(stall_count), 32'd0);
    chk("midrst_valid", 32'(ID_EX_valid), 32'd0);
    chk("midrst_pcwrite", 32'(PCWrite), 32'd1);

    // saturation with a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      present(32'h600 + 32'(8 * i), 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, C_LW);
      tick();
      present(32'h604 + 32'(8 * i), 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, C_ADD);
      tick();
      chk("sat_cnt", 32'(stall_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_cnt", 32'(stall_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
